// File: rtl/key_demux_if.sv
// key_demux_if: pin bundle between the board keys/LEDs and key_demux_stepper.
// Keys are active-low levels (pressed = 0); LEDs are active-low (lit = 0).
// There is no valid/ready handshake: every signal is a free-running level,
// sampled or driven on every clk edge.
interface key_demux_if #(
  parameter int N_OUT = 4,
  parameter int SEL_W = $clog2(N_OUT)
);
  logic             in_data;
  logic             in_step;
  logic [N_OUT-1:0] out_dmx;
  logic [SEL_W-1:0] out_sel;
  logic             vcc_for_keys;

  // Board/bench side: drives the keys, observes the LEDs.
  modport master (
    output in_data, in_step,
    input  out_dmx, out_sel, vcc_for_keys
  );

  // Demux side: reads the keys, drives the LEDs.
  modport slave (
    input  in_data, in_step,
    output out_dmx, out_sel, vcc_for_keys
  );
endinterface

// File: rtl/key_demux_stepper.sv
// key_demux_stepper: sequential 1-to-N_OUT demultiplexer driven by two keys.
// The data key level (debounced) is routed to the channel picked by a selector;
// each debounced press of the step key advances the selector with wrap.
// Optional build macro KEY_DEMUX_HOLD_EN: unselected channels keep their last
// value instead of being forced off.
module key_demux_stepper #(
  parameter int N_OUT           = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int SEL_W           = $clog2(N_OUT)
) (
  input logic       clk,
  input logic       rst_n,
  key_demux_if.slave bus
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(N_OUT - 1);

  // Key index 0 is data, 1 is step; logical 1 means pressed.
  logic [1:0]       key_raw;
  logic [1:0]       rst_sync;
  logic             rst_int_n;
  logic [1:0]       sync1;
  logic [1:0]       sync2;
  logic [1:0]       stable;
  logic [CNT_W-1:0] cnt [2];
  logic             step_prev;
  logic             step_rise;
  logic [SEL_W-1:0] sel;
  logic [N_OUT-1:0] dmx;

  assign key_raw   = {~bus.in_step, ~bus.in_data};
  assign rst_int_n = rst_sync[1];
  assign step_rise = stable[1] & ~step_prev;

  // Reset asserts immediately and releases two clk edges after rst_n rises.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync <= 2'b00;
    end else begin
      rst_sync <= {rst_sync[0], 1'b1};
    end
  end

  // Two-flop synchronizer per key; released (0) out of reset.
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      sync1 <= 2'b00;
      sync2 <= 2'b00;
    end else begin
      sync1 <= key_raw;
      sync2 <= sync1;
    end
  end

  // Debounce: a new level must persist DEBOUNCE_CYCLES edges; any bounce restarts.
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      stable <= 2'b00;
      cnt[0] <= '0;
      cnt[1] <= '0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (sync2[k] == stable[k]) begin
          cnt[k] <= '0;
        end else if (cnt[k] == CNT_LAST) begin
          stable[k] <= sync2[k];
          cnt[k]    <= '0;
        end else begin
          cnt[k] <= cnt[k] + 1'b1;
        end
      end
    end
  end

  // Selector advances once per debounced step press, wrapping at N_OUT-1.
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      step_prev <= 1'b0;
      sel       <= '0;
    end else begin
      step_prev <= stable[1];
      if (step_rise) begin
        sel <= (sel == SEL_LAST) ? '0 : sel + 1'b1;
      end
    end
  end

  // Demux register: selected channel follows the debounced data level.
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      dmx <= '0;
    end else begin
      for (int i = 0; i < N_OUT; i++) begin
        if (sel == SEL_W'(i)) begin
          dmx[i] <= stable[0];
        end else begin
`ifdef KEY_DEMUX_HOLD_EN
          dmx[i] <= dmx[i];
`else
          dmx[i] <= 1'b0;
`endif
        end
      end
    end
  end

  assign bus.out_dmx      = ~dmx;
  assign bus.out_sel      = ~sel;
  assign bus.vcc_for_keys = 1'b1;

endmodule

// File: tb/tb_key_demux_stepper.sv
// tb_key_demux_stepper: directed scenarios for key_demux_stepper with
// DEBOUNCE_CYCLES=4, N_OUT=4. Every change seen on {out_dmx,out_sel} is matched
// against an expected queue entry holding the value and the allowed cycle window.
module tb_key_demux_stepper;

  localparam int N_OUT = 4;
  localparam int DB    = 4;
  localparam int SEL_W = 2;
  localparam int W     = N_OUT + SEL_W;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  key_demux_if #(.N_OUT(N_OUT)) bus ();

  key_demux_stepper #(
    .N_OUT(N_OUT),
    .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int           lo_q[$];
  int           hi_q[$];
  int           total = 0;
  int           bad   = 0;
  logic         mon_en = 1'b0;
  logic [W-1:0] last_out = '1;
  logic [W-1:0] cur_out;

  assign cur_out = {bus.out_dmx, bus.out_sel};

  task automatic expect_out(input logic [W-1:0] v, input int lo, input int hi);
    exp_q.push_back(v);
    lo_q.push_back(lo);
    hi_q.push_back(hi);
  endtask

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%b required=%b", name, act, req);
    end
  endtask

  // Monitor: every output change must match the head of the expected queue.
  always @(negedge clk) begin
    if (mon_en && cur_out !== last_out) begin
      logic [W-1:0] e;
      int lo, hi;
      last_out = cur_out;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_change: actual=%b required=no change cyc=%0d", cur_out, cyc);
      end else begin
        e  = exp_q.pop_front();
        lo = lo_q.pop_front();
        hi = hi_q.pop_front();
        if (cur_out !== e) begin
          bad++;
          $display("FAIL out_value: actual=%b required=%b cyc=%0d", cur_out, e, cyc);
        end
        total++;
        if (cyc < lo || cyc > hi) begin
          bad++;
          $display("FAIL out_timing: actual cyc=%0d required=%0d..%0d value=%b", cyc, lo, hi, e);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press_step_clean(input logic [W-1:0] v);
    int t;
    t = cyc;
    bus.in_step = 1'b0;
    expect_out(v, t + 7, t + 7);
    tick(10);
    bus.in_step = 1'b1;
    tick(10);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int t;
    logic [SEL_W-1:0] sel_model;

    bus.in_data = 1'b1;
    bus.in_step = 1'b1;
    rst_n       = 1'b0;
    tick(3);
    check("rst_dmx", {2'b00, bus.out_dmx}, {2'b00, 4'b1111});
    check("rst_sel", {4'b0000, bus.out_sel}, {4'b0000, 2'b11});
    check("rst_vcc", {5'b00000, bus.vcc_for_keys}, 6'd1);
    rst_n = 1'b1;
    tick(5);
    check("rel_dmx", {2'b00, bus.out_dmx}, {2'b00, 4'b1111});
    check("rel_sel", {4'b0000, bus.out_sel}, {4'b0000, 2'b11});
    check("rel_vcc", {5'b00000, bus.vcc_for_keys}, 6'd1);
    mon_en = 1'b1;

    // Data latency: pin change at edge t reaches the LED after edge t+7.
    t = cyc;
    bus.in_data = 1'b0;
    expect_out({4'b1110, 2'b11}, t + 7, t + 7);
    tick(12);
    t = cyc;
    bus.in_data = 1'b1;
    expect_out({4'b1111, 2'b11}, t + 7, t + 7);
    tick(12);

    // Bounce rejection: 2-cycle pulses never qualify.
    for (int i = 0; i < 10; i++) begin
      bus.in_data = (i % 2 == 0) ? 1'b0 : 1'b1;
      tick(2);
    end
    bus.in_data = 1'b1;
    tick(12);

    // Step wrap: selector 1,2,3,0,1.
    sel_model = '0;
    for (int p = 0; p < 5; p++) begin
      sel_model = (sel_model == 2'd3) ? 2'd0 : sel_model + 2'd1;
      press_step_clean({4'b1111, ~sel_model});
    end

    // Advance to selector 2.
    press_step_clean({4'b1111, 2'b01});

    // Moving lit channel.
    t = cyc;
    bus.in_data = 1'b0;
    expect_out({4'b1011, 2'b01}, t + 7, t + 7);
    tick(12);
    t = cyc;
    bus.in_step = 1'b0;
    expect_out({4'b1011, 2'b00}, t + 7, t + 7);
`ifdef KEY_DEMUX_HOLD_EN
    expect_out({4'b0011, 2'b00}, t + 8, t + 8);
`else
    expect_out({4'b0111, 2'b00}, t + 8, t + 8);
`endif
    tick(10);
    bus.in_step = 1'b1;
    tick(10);
    t = cyc;
    bus.in_data = 1'b1;
`ifdef KEY_DEMUX_HOLD_EN
    expect_out({4'b1011, 2'b00}, t + 7, t + 7);
`else
    expect_out({4'b1111, 2'b00}, t + 7, t + 7);
`endif
    tick(12);

    // Reset clears everything immediately.
    t = cyc;
    rst_n = 1'b0;
    expect_out({4'b1111, 2'b11}, t, t);
    tick(3);

    // Key pressed through reset must re-qualify after release.
    bus.in_data = 1'b0;
    tick(3);
    t = cyc;
    rst_n = 1'b1;
    expect_out({4'b1110, 2'b11}, t + 7, t + 9);
    tick(15);

    // Simultaneous data and step press: old channel first, then new channel.
    t = cyc;
    bus.in_data = 1'b1;
    expect_out({4'b1111, 2'b11}, t + 7, t + 7);
    tick(12);
    t = cyc;
    bus.in_data = 1'b0;
    bus.in_step = 1'b0;
    expect_out({4'b1110, 2'b10}, t + 7, t + 7);
`ifdef KEY_DEMUX_HOLD_EN
    expect_out({4'b1100, 2'b10}, t + 8, t + 8);
`else
    expect_out({4'b1101, 2'b10}, t + 8, t + 8);
`endif
    tick(12);
    t = cyc;
    bus.in_data = 1'b1;
    bus.in_step = 1'b1;
`ifdef KEY_DEMUX_HOLD_EN
    expect_out({4'b1110, 2'b10}, t + 7, t + 7);
`else
    expect_out({4'b1111, 2'b10}, t + 7, t + 7);
`endif
    tick(12);

    // Every expected change must have appeared.
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL missing_changes: actual=%0d pending required=0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
